// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared definitions for the program-counter sequencer and the fetch stage:
//   the sequencer state encoding, the default code-memory word-address width,
//   and helpers that derive the word count and the byte-range limit from it.
//   All limits are 33 bits wide so that a 2^32-byte code space still compares
//   correctly.

package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } pc_state_e;

  localparam int CODE_ADDR_WIDTH_DEF = 10;

  function automatic logic [32:0] code_words(input int unsigned aw);
    return 33'd1 << aw;
  endfunction

  // First illegal byte address: 4 * code_words.
  function automatic logic [32:0] code_bytes(input int unsigned aw);
    return code_words(aw) << 2;
  endfunction

  // A target is legal when it is word-aligned and inside [0, lim).
  function automatic logic addr_legal(input logic [31:0] addr, input logic [32:0] lim);
    return (addr[1:0] == 2'b00) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/pc_sequencer_perf_counters.sv
// pc_seq_perf_counters
//   Two free-running 32-bit event counters for the PC sequencer.
//   Both wrap mod 2^32 and clear on synchronous reset.
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   fetch_i         count one fetch this cycle
//   bubble_i        count one bubble this cycle
//   fetch_count_o   number of fetch cycles since reset
//   bubble_count_o  number of bubble cycles since reset

module pc_seq_perf_counters (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_i,
  input  logic        bubble_i,
  output logic [31:0] fetch_count_o,
  output logic [31:0] bubble_count_o
);

  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (fetch_i)  fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (bubble_i) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_count_o  = fetch_cnt_q;
  assign bubble_count_o = bubble_cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter stage in front of instruction fetch. Presents a word-aligned
//   pc and do_fetch; fetch registers inst one cycle later. This block tracks the
//   pc of that registered inst and whether it is live, and handles stall, branch
//   redirect (one bubble) and a sticky fault on a bad address.
//   Optional perf counters are built only when PC_SEQ_PERF_EN is defined;
//   otherwise fetch_count/bubble_count are tied to zero.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   stall                      hold front end, no new fetch
//   redirect_valid/_target     taken branch/exception and its byte address
//   pc, do_fetch               address and enable towards fetch
//   inst_valid, inst_pc        liveness and address of fetch's inst register
//   inst_pc_plus8              inst_pc + 8 (ARM-visible PC)
//   fault                      sticky bad-address indication
//   fetch_count, bubble_count  perf counters
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BOOT  | one idle cycle after reset; redirect still accepted
// ST_RUN   | fetching; redirect > stall > advance
// ST_FAULT | stopped on bad address; left only by rst

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter int          CODE_ADDR_WIDTH = CODE_ADDR_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic        do_fetch,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus8,
  output logic        fault,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  localparam logic [32:0] CODE_BYTES = code_bytes(CODE_ADDR_WIDTH);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fault_q, fault_d;
  logic        do_fetch_c;
  logic        target_ok;
  logic [32:0] pc_plus4;

  assign target_ok = addr_legal(redirect_target, CODE_BYTES);
  // One extra bit so stepping off the top of a 2^32 space is still caught.
  assign pc_plus4  = {1'b0, pc_q} + 33'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      inst_pc_q    <= RESET_VECTOR;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fault_d      = fault_q;
    do_fetch_c   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (redirect_valid) begin
          if (target_ok) begin
            pc_d = redirect_target;
          end else begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        do_fetch_c = !stall && !redirect_valid;
        if (redirect_valid) begin
          // Squash the wrong-path slot regardless of target legality.
          inst_valid_d = 1'b0;
          if (target_ok) begin
            pc_d = redirect_target;
          end else begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end
        end else if (!stall) begin
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          // The last word is still fetched and delivered; only the step
          // beyond it faults, with pc left on the last word.
          if (pc_plus4 >= CODE_BYTES) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = pc_plus4[31:0];
          end
        end
      end

      ST_FAULT: begin
        inst_valid_d = 1'b0;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign pc            = pc_q;
  assign do_fetch      = do_fetch_c;
  assign inst_valid    = inst_valid_q;
  assign inst_pc       = inst_pc_q;
  assign inst_pc_plus8 = inst_pc_q + 32'd8;
  assign fault         = fault_q;

`ifdef PC_SEQ_PERF_EN
  logic bubble_c;
  assign bubble_c = (state_q == ST_RUN) && (!inst_valid_q || stall);

  pc_seq_perf_counters u_perf (
    .clk_i          (clk),
    .rst_i          (rst),
    .fetch_i        (do_fetch_c),
    .bubble_i       (bubble_c),
    .fetch_count_o  (fetch_count),
    .bubble_count_o (bubble_count)
  );
`else
  assign fetch_count  = 32'd0;
  assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic        do_fetch;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus8;
  logic        fault;
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer #(
    .RESET_VECTOR    (32'h0000_0000),
    .CODE_ADDR_WIDTH (10)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc),
    .do_fetch        (do_fetch),
    .inst_valid      (inst_valid),
    .inst_pc         (inst_pc),
    .inst_pc_plus8   (inst_pc_plus8),
    .fault           (fault),
    .fetch_count     (fetch_count),
    .bubble_count    (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    // BOOT cycle
    n_vec++; if (do_fetch !== 1'b0) begin n_err++; $display("FAIL boot_do_fetch got=%0b exp=0", do_fetch); end
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL boot_pc got=%h exp=0", pc); end
    n_vec++; if (inst_valid !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL boot_flags valid=%0b fault=%0b exp=0/0", inst_valid, fault); end
    n_vec++; if (fetch_count !== 32'h0 || bubble_count !== 32'h0) begin n_err++; $display("FAIL boot_counters f=%0d b=%0d exp=0/0", fetch_count, bubble_count); end
    cyc();
    n_vec++; if (pc !== 32'h0 || do_fetch !== 1'b1) begin n_err++; $display("FAIL first_fetch pc=%h df=%0b exp=0/1", pc, do_fetch); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL first_fetch_valid got=%0b exp=0", inst_valid); end
    cyc();
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_pc_plus8 !== 32'h8 || pc !== 32'h4)
      begin n_err++; $display("FAIL first_inst valid=%0b ipc=%h p8=%h pc=%h exp=1/0/8/4", inst_valid, inst_pc, inst_pc_plus8, pc); end
`ifdef PC_SEQ_PERF_EN
    // fetches at pc=0 and pc=4 pending: one counted so far; one bubble (RUN, invalid)
    n_vec++; if (fetch_count !== 32'd1 || bubble_count !== 32'd1) begin n_err++; $display("FAIL perf_start f=%0d b=%0d exp=1/1", fetch_count, bubble_count); end
`endif
  endtask

  task automatic test_stall();
    cyc();
    n_vec++; if (pc !== 32'h8 || inst_pc !== 32'h4) begin n_err++; $display("FAIL pre_stall pc=%h ipc=%h exp=8/4", pc, inst_pc); end
    stall = 1'b1;
    #1;
    n_vec++; if (do_fetch !== 1'b0) begin n_err++; $display("FAIL stall_do_fetch got=%0b exp=0", do_fetch); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) stall = 1'b0;
      n_vec++; if (pc !== 32'h8 || inst_pc !== 32'h4 || inst_valid !== 1'b1)
        begin n_err++; $display("FAIL stall_hold_%0d pc=%h ipc=%h valid=%0b exp=8/4/1", i, pc, inst_pc, inst_valid); end
    end
    #1;
    n_vec++; if (do_fetch !== 1'b1) begin n_err++; $display("FAIL stall_release_df got=%0b exp=1", do_fetch); end
    cyc();
    n_vec++; if (pc !== 32'hC || inst_pc !== 32'h8) begin n_err++; $display("FAIL post_stall pc=%h ipc=%h exp=c/8", pc, inst_pc); end
  endtask

  task automatic test_redirect();
    logic [31:0] b0;
    cyc();
    n_vec++; if (pc !== 32'h10) begin n_err++; $display("FAIL pre_redirect pc=%h exp=10", pc); end
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    #1;
    b0 = bubble_count;
    n_vec++; if (do_fetch !== 1'b0) begin n_err++; $display("FAIL redirect_df got=%0b exp=0", do_fetch); end
    cyc();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (pc !== 32'h40 || inst_valid !== 1'b0 || do_fetch !== 1'b1)
      begin n_err++; $display("FAIL redirect_bubble pc=%h valid=%0b df=%0b exp=40/0/1", pc, inst_valid, do_fetch); end
    cyc();
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_pc_plus8 !== 32'h48 || pc !== 32'h44)
      begin n_err++; $display("FAIL redirect_target_inst valid=%0b ipc=%h p8=%h pc=%h exp=1/40/48/44", inst_valid, inst_pc, inst_pc_plus8, pc); end
`ifdef PC_SEQ_PERF_EN
    n_vec++; if (bubble_count !== b0 + 32'd1) begin n_err++; $display("FAIL redirect_bubble_count got=%0d exp=%0d", bubble_count, b0 + 32'd1); end
`else
    n_vec++; if (bubble_count !== 32'h0 || fetch_count !== 32'h0) begin n_err++; $display("FAIL perf_tied f=%0d b=%0d exp=0/0", fetch_count, bubble_count); end
`endif
  endtask

  task automatic test_redirect_with_stall();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h80;
    cyc();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (pc !== 32'h80 || inst_valid !== 1'b0 || do_fetch !== 1'b0)
      begin n_err++; $display("FAIL redir_stall pc=%h valid=%0b df=%0b exp=80/0/0", pc, inst_valid, do_fetch); end
    cyc();
    n_vec++; if (pc !== 32'h80) begin n_err++; $display("FAIL redir_stall_hold pc=%h exp=80", pc); end
    stall = 1'b0;
    #1;
    n_vec++; if (do_fetch !== 1'b1) begin n_err++; $display("FAIL redir_stall_resume_df got=%0b exp=1", do_fetch); end
    cyc();
    n_vec++; if (pc !== 32'h84 || inst_valid !== 1'b1 || inst_pc !== 32'h80)
      begin n_err++; $display("FAIL redir_stall_inst pc=%h valid=%0b ipc=%h exp=84/1/80", pc, inst_valid, inst_pc); end
  endtask

  task automatic check_fault_then_reset(input string nm, input logic [31:0] exp_pc);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (fault !== 1'b1 || do_fetch !== 1'b0 || inst_valid !== 1'b0 || pc !== exp_pc)
        begin n_err++; $display("FAIL %s_stuck_%0d fault=%0b df=%0b valid=%0b pc=%h exp=1/0/0/%h", nm, i, fault, do_fetch, inst_valid, pc, exp_pc); end
      cyc();
    end
    do_reset();
    n_vec++; if (pc !== 32'h0 || fault !== 1'b0 || inst_valid !== 1'b0)
      begin n_err++; $display("FAIL %s_reset pc=%h fault=%0b valid=%0b exp=0/0/0", nm, pc, fault, inst_valid); end
  endtask

  task automatic test_fault_misaligned();
    redirect_valid = 1'b1;
    redirect_target = 32'h42;
    cyc();
    redirect_valid = 1'b0;
    #1;
    check_fault_then_reset("misaligned", 32'h84);
  endtask

  task automatic test_boot_redirect_and_range();
    // Redirect during the BOOT cycle
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (pc !== 32'h100 || do_fetch !== 1'b1 || inst_valid !== 1'b0)
      begin n_err++; $display("FAIL boot_redirect pc=%h df=%0b valid=%0b exp=100/1/0", pc, do_fetch, inst_valid); end
    cyc();
    n_vec++; if (inst_pc !== 32'h100 || inst_valid !== 1'b1 || pc !== 32'h104)
      begin n_err++; $display("FAIL boot_redirect_inst ipc=%h valid=%0b pc=%h exp=100/1/104", inst_pc, inst_valid, pc); end
    redirect_valid = 1'b1;
    redirect_target = 32'h1000;
    cyc();
    redirect_valid = 1'b0;
    #1;
    check_fault_then_reset("out_of_range", 32'h104);
  endtask

  task automatic test_last_word();
    redirect_valid = 1'b1;
    redirect_target = 32'hFF4;
    cyc();
    redirect_valid = 1'b0;
    #1;
    cyc();
    cyc();
    n_vec++; if (pc !== 32'hFFC || inst_pc !== 32'hFF8 || fault !== 1'b0 || do_fetch !== 1'b1)
      begin n_err++; $display("FAIL last_word_pc pc=%h ipc=%h fault=%0b df=%0b exp=ffc/ff8/0/1", pc, inst_pc, fault, do_fetch); end
    cyc();
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFC || inst_pc_plus8 !== 32'h1004 || pc !== 32'hFFC || fault !== 1'b1 || do_fetch !== 1'b0)
      begin n_err++; $display("FAIL last_word_inst valid=%0b ipc=%h p8=%h pc=%h fault=%0b df=%0b exp=1/ffc/1004/ffc/1/0",
                              inst_valid, inst_pc, inst_pc_plus8, pc, fault, do_fetch); end
    cyc();
    n_vec++; if (inst_valid !== 1'b0 || pc !== 32'hFFC || fault !== 1'b1)
      begin n_err++; $display("FAIL last_word_after valid=%0b pc=%h fault=%0b exp=0/ffc/1", inst_valid, pc, fault); end
    do_reset();
    n_vec++; if (pc !== 32'h0 || fault !== 1'b0) begin n_err++; $display("FAIL last_word_reset pc=%h fault=%0b exp=0/0", pc, fault); end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_with_stall();
    test_fault_misaligned();
    test_boot_redirect_and_range();
    test_last_word();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
